// File: rtl/mc_controller_if.sv
// mc_controller_if: shared instruction/data memory port.
// The controller masters the request; memory answers with ready.
interface mc_controller_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define MC_CTRL_JUMP_EN to make JAL, JALR and LUI legal.
module mc_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  mc_controller_if.master  mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             bus_err,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);
  localparam int TW =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [6:0]     op_q;
  logic [TW-1:0]  tcnt;
  logic           tmo_hit;
  logic           set_ill;
  logic           set_be;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: is_legal = 1'b1;
`ifdef MC_CTRL_JUMP_EN
      OP_JAL, OP_JALR, OP_LUI: is_legal = 1'b1;
`endif
      default: is_legal = 1'b0;
    endcase
  endfunction

  assign state   = state_q;
  assign tmo_hit = (MEM_TIMEOUT != 0) &&
                   (tcnt == TW'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.i_or_d  = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_src     = 1'b0;
    alu_op      = 2'b00;
    mem_to_reg  = 2'b00;
    reg_write   = 1'b0;
    retire      = 1'b0;
    set_ill     = 1'b0;
    set_be      = 1'b0;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (tmo_hit) begin
          set_be  = 1'b1;
          state_d = TRAP;
        end
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          set_ill = 1'b1;
          state_d = TRAP;
        end
      end
      EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op  = 2'b10;
            state_d = WB;
          end
          OP_I: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            state_d = WB;
          end
          OP_LW, OP_SW: begin
            alu_src = 1'b1;
            state_d = MEM;
          end
          OP_BEQ: begin
            alu_op   = 2'b01;
            pc_write = zero;
            pc_src   = 2'b01;
            retire   = 1'b1;
            state_d  = FETCH;
          end
`ifdef MC_CTRL_JUMP_EN
          OP_JAL: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            retire     = 1'b1;
            state_d    = FETCH;
          end
          OP_JALR: begin
            alu_src    = 1'b1;
            reg_write  = 1'b1;
            mem_to_reg = 2'b10;
            pc_write   = 1'b1;
            pc_src     = 2'b11;
            retire     = 1'b1;
            state_d    = FETCH;
          end
          OP_LUI: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b11;
            retire     = 1'b1;
            state_d    = FETCH;
          end
`endif
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        mem.mem_req = 1'b1;
        mem.i_or_d  = 1'b1;
        mem.mem_we  = (op_q == OP_SW);
        if (mem.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end else if (tmo_hit) begin
          set_be  = 1'b1;
          state_d = TRAP;
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
        case (op_q)
          OP_LW: begin
            alu_src    = 1'b1;
            mem_to_reg = 2'b01;
          end
          OP_I: begin
            alu_src = 1'b1;
            alu_op  = 2'b11;
          end
          default: alu_op = 2'b10;
        endcase
      end
      TRAP: state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Wait counter restarts whenever a new request phase begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 7'd0;
      instret <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
      tcnt    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= opcode;
      if (set_ill) illegal <= 1'b1;
      if (set_be) bus_err <= 1'b1;
      if (retire) instret <= instret + CNT_W'(1);
      if (state_d != state_q &&
          (state_d == FETCH || state_d == MEM))
        tcnt <= '0;
      else if (mem.mem_req && !mem.mem_ready)
        tcnt <= tcnt + TW'(1);
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-cycle scoreboard bench for mc_controller.
// Built with MEM_TIMEOUT=3 and a 4-bit instret to reach the wrap.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       ir_write, pc_write, alu_src;
  logic       reg_write, illegal, bus_err, retire;
  logic [1:0] pc_src, alu_op, mem_to_reg;
  logic [2:0] state;
  logic [3:0] instret;

  mc_controller_if mif ();

  mc_controller #(.MEM_TIMEOUT(3), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .state      (state),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .retire     (retire),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [13:0] ctl;
    logic        ill;
    logic        be;
    logic [3:0]  ir;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   ncyc   = 0;
  logic [3:0] exp_ir = 4'd0;

  localparam logic [2:0] S_IDLE = 3'd0, S_FET = 3'd1, S_DEC = 3'd2;
  localparam logic [2:0] S_EX = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd7;

  // {req,we,i_or_d,ir_wr,pc_wr,pc_src,alu_src,alu_op,m2r,reg_wr,retire}
  localparam logic [13:0] C0     = 14'b0_0_0_0_0_00_0_00_00_0_0;
  localparam logic [13:0] C_FR   = 14'b1_0_0_1_1_00_0_00_00_0_0;
  localparam logic [13:0] C_FW   = 14'b1_0_0_0_0_00_0_00_00_0_0;
  localparam logic [13:0] C_EXR  = 14'b0_0_0_0_0_00_0_10_00_0_0;
  localparam logic [13:0] C_WBR  = 14'b0_0_0_0_0_00_0_10_00_1_1;
  localparam logic [13:0] C_EXI  = 14'b0_0_0_0_0_00_1_11_00_0_0;
  localparam logic [13:0] C_WBI  = 14'b0_0_0_0_0_00_1_11_00_1_1;
  localparam logic [13:0] C_EXM  = 14'b0_0_0_0_0_00_1_00_00_0_0;
  localparam logic [13:0] C_MLW  = 14'b1_0_1_0_0_00_0_00_00_0_0;
  localparam logic [13:0] C_MSWW = 14'b1_1_1_0_0_00_0_00_00_0_0;
  localparam logic [13:0] C_MSWR = 14'b1_1_1_0_0_00_0_00_00_0_1;
  localparam logic [13:0] C_WBLW = 14'b0_0_0_0_0_00_1_00_01_1_1;
  localparam logic [13:0] C_BQT  = 14'b0_0_0_0_1_01_0_01_00_0_1;
  localparam logic [13:0] C_BQN  = 14'b0_0_0_0_0_01_0_01_00_0_1;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [13:0] C_JAL  = 14'b0_0_0_0_1_10_0_00_10_1_1;
  localparam logic [13:0] C_LUI  = 14'b0_0_0_0_0_00_0_00_11_1_1;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // One cycle: drive inputs after the edge, queue what it must show.
  task automatic cyc(input logic rst, input logic rdy,
                     input logic z, input logic [2:0] st,
                     input logic [13:0] ctl,
                     input logic ill, input logic be);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      reset  = 1'b1;
      exp_ir = 4'd0;
    end
    mif.mem_ready = rdy;
    zero          = z;
    e.st  = st;
    e.ctl = ctl;
    e.ill = ill;
    e.be  = be;
    e.ir  = exp_ir;
    sb.push_back(e);
    if (ctl[0]) exp_ir = exp_ir + 4'd1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_r();
    opcode = OP_R;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_EXR, 0, 0);
    cyc(0, 1, 0, S_WB, C_WBR, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [13:0] act;
    ncyc++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      act = {mif.mem_req, mif.mem_we, mif.i_or_d, ir_write, pc_write,
             pc_src, alu_src, alu_op, mem_to_reg, reg_write, retire};
      total++;
      if (state === e.st && act === e.ctl && illegal === e.ill &&
          bus_err === e.be && instret === e.ir)
        passed++;
      else
        $display("FAIL cyc%0d st/ctl/ill/be/instret: got %0d %b %b %b %0d, want %0d %b %b %b %0d",
                 ncyc, state, act, illegal, bus_err, instret,
                 e.st, e.ctl, e.ill, e.be, e.ir);
    end
  end

  initial begin
    reset         = 1'b1;
    opcode        = 7'd0;
    zero          = 1'b0;
    mif.mem_ready = 1'b0;
    cyc(1, 0, 0, S_IDLE, C0, 0, 0);
    cyc(1, 1, 0, S_IDLE, C0, 0, 0);
    release_rst();

    run_r();

    opcode = OP_LW;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_EXM, 0, 0);
    cyc(0, 0, 0, S_MEM, C_MLW, 0, 0);
    cyc(0, 0, 0, S_MEM, C_MLW, 0, 0);
    cyc(0, 1, 0, S_MEM, C_MLW, 0, 0);
    cyc(0, 0, 0, S_WB, C_WBLW, 0, 0);

    opcode = OP_SW;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 0, 0, S_DEC, C0, 0, 0);
    cyc(0, 0, 0, S_EX, C_EXM, 0, 0);
    cyc(0, 0, 0, S_MEM, C_MSWW, 0, 0);
    cyc(0, 1, 0, S_MEM, C_MSWR, 0, 0);

    opcode = OP_I;
    cyc(0, 0, 0, S_FET, C_FW, 0, 0);
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_EXI, 0, 0);
    cyc(0, 1, 0, S_WB, C_WBI, 0, 0);

    opcode = OP_BEQ;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 1, S_EX, C_BQT, 0, 0);
    cyc(0, 1, 1, S_FET, C_FR, 0, 0);
    cyc(0, 1, 1, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_BQN, 0, 0);

    // Ready on the last allowed wait cycle still completes.
    opcode = OP_R;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, S_FET, C_FW, 0, 0);
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_EXR, 0, 0);
    cyc(0, 1, 0, S_WB, C_WBR, 0, 0);

    for (int i = 0; i < 16; i++) run_r();

`ifdef MC_CTRL_JUMP_EN
    opcode = OP_JAL;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_JAL, 0, 0);
    opcode = 7'b0110111;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_LUI, 0, 0);
`else
    opcode = OP_JAL;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_TRAP, C0, 1, 0);
    cyc(1, 0, 0, S_IDLE, C0, 0, 0);
    release_rst();
`endif

    opcode = OP_BAD;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      automatic logic r = logic'(i % 2);
      cyc(0, r, 0, S_TRAP, C0, 1, 0);
    end
    cyc(1, 0, 0, S_IDLE, C0, 0, 0);
    release_rst();

    opcode = OP_R;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, S_FET, C_FW, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, i == 1, 0, S_TRAP, C0, 0, 1);
    cyc(1, 0, 0, S_IDLE, C0, 0, 0);
    release_rst();

    run_r();
    opcode = OP_LW;
    cyc(0, 1, 0, S_FET, C_FR, 0, 0);
    cyc(0, 1, 0, S_DEC, C0, 0, 0);
    cyc(0, 1, 0, S_EX, C_EXM, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, S_MEM, C_MLW, 0, 0);
    cyc(0, 1, 0, S_TRAP, C0, 0, 1);
    cyc(1, 0, 0, S_IDLE, C0, 0, 0);
    release_rst();

    // Reset in the middle of a pending fetch drops the request at once.
    run_r();
    cyc(0, 0, 0, S_FET, C_FW, 0, 0);
    cyc(1, 0, 0, S_IDLE, C0, 0, 0);
    release_rst();
    run_r();

    repeat (2) @(posedge clk);
    total++;
    if (sb.size() == 0)
      passed++;
    else
      $display("FAIL drain: got %0d queued, want 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
